// File: rtl/tile_mem_pkg.sv
// Shared types and constants for the tile memory scheduler.
package tile_mem_pkg;

  localparam int unsigned TIdxW     = 7;
  localparam int unsigned CfgW      = 7;
  localparam int unsigned TileElems = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RD_ACC = 2'd1;
  localparam logic [1:0] ST_WR_ACC = 2'd2;
  localparam logic [1:0] ST_RD_RSP = 2'd3;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } grant_e;

  typedef struct packed {
    logic [TIdxW-1:0] tile_row;
    logic [TIdxW-1:0] tile_col;
    logic [CfgW-1:0]  cfg_row;
    logic [CfgW-1:0]  cfg_col;
  } req_t;

endpackage

// File: rtl/tile_mem_scheduler_addr_gen.sv
// Tile base-address calculation and bounds check; all arithmetic at AddrWidth+8 bits.
module tile_addr_gen
  import tile_mem_pkg::*;
#(
  parameter int unsigned TileRows  = 4,
  parameter int unsigned TileCols  = 4,
  parameter int unsigned DataDepth = 1024,
  parameter int unsigned AddrWidth = 10
) (
  input  req_t                 req_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 err_o
);

  localparam int unsigned CalcW = AddrWidth + 8;

  logic [CalcW-1:0] row_w, col_w, crow_w, ccol_w;
  logic [CalcW-1:0] base, last, row_end, col_end;

  always_comb begin
    row_w   = CalcW'(req_i.tile_row);
    col_w   = CalcW'(req_i.tile_col);
    crow_w  = CalcW'(req_i.cfg_row);
    ccol_w  = CalcW'(req_i.cfg_col);
    base    = row_w * CalcW'(TileRows) * ccol_w + col_w * CalcW'(TileCols);
    last    = base + CalcW'(TileRows - 1) * ccol_w + CalcW'(TileCols - 1);
    row_end = (row_w + CalcW'(1)) * CalcW'(TileRows);
    col_end = (col_w + CalcW'(1)) * CalcW'(TileCols);
    err_o   = (row_end > crow_w) || (col_end > ccol_w) || (ccol_w == '0) ||
              (last >= CalcW'(DataDepth));
    addr_o  = AddrWidth'(base);
  end

endmodule

// File: rtl/tile_mem_scheduler.sv
// Read/write arbiter in front of a single-port tile-access matrix memory.
// Optional TILE_SCHED_PERF_EN adds saturating request/stall counters.
module tile_mem_scheduler
  import tile_mem_pkg::*;
#(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned MemoryRows    = 32,
  parameter int unsigned MemoryColumns = 32,
  parameter int unsigned TileRows      = 4,
  parameter int unsigned TileCols      = 4
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic [CfgW-1:0]                             cfg_matrix_row_i,
  input  logic [CfgW-1:0]                             cfg_matrix_col_i,
  input  logic                                        rd_req_valid_i,
  output logic                                        rd_req_ready_o,
  input  logic [TIdxW-1:0]                            rd_tile_row_i,
  input  logic [TIdxW-1:0]                            rd_tile_col_i,
  output logic                                        rd_rsp_valid_o,
  input  logic                                        rd_rsp_ready_i,
  output logic                                        rd_rsp_err_o,
  output logic [TileRows*TileCols-1:0][DataWidth-1:0] rd_rsp_data_o,
  input  logic                                        wr_req_valid_i,
  output logic                                        wr_req_ready_o,
  input  logic [TIdxW-1:0]                            wr_tile_row_i,
  input  logic [TIdxW-1:0]                            wr_tile_col_i,
  input  logic [TileRows*TileCols-1:0][DataWidth-1:0] wr_data_i,
  output logic                                        wr_err_o,
  output logic [$clog2(MemoryRows*MemoryColumns)-1:0] mem_addr_o,
  output logic                                        mem_we_o,
  output logic [CfgW-1:0]                             mem_matrix_col_o,
  output logic [TileRows*TileCols-1:0][DataWidth-1:0] mem_wr_data_o,
  input  logic [TileRows*TileCols-1:0][DataWidth-1:0] mem_rd_data_i,
  output logic                                        busy_o
`ifdef TILE_SCHED_PERF_EN
  ,
  input  logic                                        perf_clr_i,
  output logic [31:0]                                 perf_rd_cnt_o,
  output logic [31:0]                                 perf_wr_cnt_o,
  output logic [31:0]                                 perf_stall_cnt_o
`endif
);

  localparam int unsigned DataDepth = MemoryRows * MemoryColumns;
  localparam int unsigned AddrWidth = $clog2(DataDepth);
  localparam int unsigned TileN     = TileRows * TileCols;

  typedef logic [TileN-1:0][DataWidth-1:0] tile_t;

  logic [1:0]           state_q, state_d;
  grant_e               last_q, last_d;
  req_t                 req_q, req_d;
  tile_t                rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 acc_err_q;
  logic                 req_rdy_q;
  logic                 rsp_valid_q;
  logic [AddrWidth-1:0] mem_addr_q;
  logic                 mem_we_q;
  tile_t                mem_wdata_q;
  logic                 wr_err_q;
  logic                 busy_q;
  logic                 gnt_rd, gnt_wr;
  logic [AddrWidth-1:0] ag_addr;
  logic                 ag_err;

  // Address generator sees the request being latched so access outputs can be registered.
  tile_addr_gen #(
    .TileRows (TileRows),
    .TileCols (TileCols),
    .DataDepth(DataDepth),
    .AddrWidth(AddrWidth)
  ) u_addr_gen (
    .req_i (req_d),
    .addr_o(ag_addr),
    .err_o (ag_err)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      last_q  <= GNT_WR;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    req_d      = req_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    gnt_rd     = 1'b0;
    gnt_wr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Ties go to the side that did not win last time.
        gnt_rd = req_rdy_q && rd_req_valid_i && (!wr_req_valid_i || last_q == GNT_WR);
        gnt_wr = req_rdy_q && wr_req_valid_i && !gnt_rd;
        if (gnt_rd) begin
          req_d   = '{tile_row: rd_tile_row_i, tile_col: rd_tile_col_i,
                      cfg_row: cfg_matrix_row_i, cfg_col: cfg_matrix_col_i};
          state_d = ST_RD_ACC;
          last_d  = GNT_RD;
        end else if (gnt_wr) begin
          req_d   = '{tile_row: wr_tile_row_i, tile_col: wr_tile_col_i,
                      cfg_row: cfg_matrix_row_i, cfg_col: cfg_matrix_col_i};
          state_d = ST_WR_ACC;
          last_d  = GNT_WR;
        end
      end
      ST_RD_ACC: begin
        rsp_err_d  = acc_err_q;
        rsp_data_d = acc_err_q ? '0 : mem_rd_data_i;
        state_d    = ST_RD_RSP;
      end
      ST_WR_ACC: state_d = ST_IDLE;
      ST_RD_RSP: if (rd_rsp_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs, all derived from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      acc_err_q   <= 1'b0;
      req_rdy_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      wr_err_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      req_q       <= req_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      acc_err_q   <= ag_err;
      req_rdy_q   <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RD_RSP);
      mem_addr_q  <= ((gnt_rd || gnt_wr) && !ag_err) ? ag_addr : '0;
      mem_we_q    <= gnt_wr && !ag_err;
      mem_wdata_q <= (gnt_wr && !ag_err) ? wr_data_i : '0;
      wr_err_q    <= gnt_wr && ag_err;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign rd_req_ready_o   = req_rdy_q;
  assign wr_req_ready_o   = req_rdy_q;
  assign rd_rsp_valid_o   = rsp_valid_q;
  assign rd_rsp_err_o     = rsp_err_q;
  assign rd_rsp_data_o    = rsp_data_q;
  assign wr_err_o         = wr_err_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_we_o         = mem_we_q;
  assign mem_matrix_col_o = req_q.cfg_col;
  assign mem_wr_data_o    = mem_wdata_q;
  assign busy_o           = busy_q;

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] perf_rd_q, perf_wr_q, perf_stall_q;
  logic        stall;

  assign stall = !req_rdy_q && (rd_req_valid_i || wr_req_valid_i);

  // Saturating counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_rd_q    <= '0;
      perf_wr_q    <= '0;
      perf_stall_q <= '0;
    end else if (perf_clr_i) begin
      perf_rd_q    <= '0;
      perf_wr_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      if (gnt_rd && perf_rd_q != '1)   perf_rd_q    <= perf_rd_q + 32'd1;
      if (gnt_wr && perf_wr_q != '1)   perf_wr_q    <= perf_wr_q + 32'd1;
      if (stall && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_rd_cnt_o    = perf_rd_q;
  assign perf_wr_cnt_o    = perf_wr_q;
  assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_tile_mem_scheduler.sv
// Directed bench for tile_mem_scheduler with a behavioural tile-access memory.
module tb_tile_mem_scheduler;
  import tile_mem_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned TR    = 4;
  localparam int unsigned TC    = 4;
  localparam int unsigned DEPTH = 32 * 32;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef logic [TileElems-1:0][DW-1:0] tile_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [6:0]    cfg_matrix_row_i, cfg_matrix_col_i;
  logic          rd_req_valid_i, rd_req_ready_o;
  logic [6:0]    rd_tile_row_i, rd_tile_col_i;
  logic          rd_rsp_valid_o, rd_rsp_ready_i, rd_rsp_err_o;
  tile_t         rd_rsp_data_o;
  logic          wr_req_valid_i, wr_req_ready_o;
  logic [6:0]    wr_tile_row_i, wr_tile_col_i;
  tile_t         wr_data_i;
  logic          wr_err_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [6:0]    mem_matrix_col_o;
  tile_t         mem_wr_data_o, mem_rd_data_i;
  logic          busy_o;

  tile_mem_scheduler dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_matrix_row_i(cfg_matrix_row_i), .cfg_matrix_col_i(cfg_matrix_col_i),
    .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
    .rd_tile_row_i(rd_tile_row_i), .rd_tile_col_i(rd_tile_col_i),
    .rd_rsp_valid_o(rd_rsp_valid_o), .rd_rsp_ready_i(rd_rsp_ready_i),
    .rd_rsp_err_o(rd_rsp_err_o), .rd_rsp_data_o(rd_rsp_data_o),
    .wr_req_valid_i(wr_req_valid_i), .wr_req_ready_o(wr_req_ready_o),
    .wr_tile_row_i(wr_tile_row_i), .wr_tile_col_i(wr_tile_col_i),
    .wr_data_i(wr_data_i), .wr_err_o(wr_err_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_matrix_col_o(mem_matrix_col_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_rd_data_i(mem_rd_data_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural memory: element (r,c) of a tile lives at addr + r*MatrixCol + c.
  logic [7:0] mem [DEPTH];
  bit         mem_ready;

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 7 + 3) % 256);
  endfunction

  function automatic int midx(input logic [AW-1:0] a, input logic [6:0] col, input int r, input int c);
    return (int'(a) + r * int'(col) + c) % DEPTH;
  endfunction

  function automatic tile_t exp_tile(input logic [AW-1:0] a, input logic [6:0] col);
    tile_t t;
    for (int r = 0; r < TR; r++)
      for (int c = 0; c < TC; c++) t[r*TC+c] = init_val(midx(a, col, r, c));
    return t;
  endfunction

  always @(posedge clk_i) begin
    if (!mem_ready) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (mem_we_o) begin
      for (int r = 0; r < TR; r++)
        for (int c = 0; c < TC; c++)
          mem[midx(mem_addr_o, mem_matrix_col_o, r, c)] <= mem_wr_data_o[r*TC+c];
    end
  end

  always_comb begin
    mem_rd_data_i = '0;
    for (int r = 0; r < TR; r++)
      for (int c = 0; c < TC; c++)
        mem_rd_data_i[r*TC+c] = mem[midx(mem_addr_o, mem_matrix_col_o, r, c)];
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cfg(input logic [6:0] crow, input logic [6:0] ccol);
    cfg_matrix_row_i = crow;
    cfg_matrix_col_i = ccol;
  endtask

  // Issues a read from IDLE and checks access and response timing; rsp_ready must be 1.
  task automatic do_read(input string nm, input logic [6:0] tr, input logic [6:0] tc,
                         input logic [AW-1:0] exp_addr, input logic exp_err, input tile_t exp_data);
    rd_tile_row_i  = tr;
    rd_tile_col_i  = tc;
    rd_req_valid_i = 1'b1;
    step();
    rd_req_valid_i = 1'b0;
    check({nm, " acc"}, 128'({rd_req_ready_o, busy_o, mem_we_o, mem_addr_o}),
          128'({1'b0, 1'b1, 1'b0, exp_err ? AW'(0) : exp_addr}));
    step();
    check({nm, " rsp"}, 128'({rd_rsp_valid_o, rd_rsp_err_o}), 128'({1'b1, exp_err}));
    check({nm, " data"}, 128'(rd_rsp_data_o), 128'(exp_data));
    step();
    check({nm, " idle"}, 128'({rd_rsp_valid_o, rd_req_ready_o, busy_o}), 128'(3'b010));
  endtask

  task automatic do_write(input logic [6:0] tr, input logic [6:0] tc, input tile_t d);
    wr_tile_row_i  = tr;
    wr_tile_col_i  = tc;
    wr_data_i      = d;
    wr_req_valid_i = 1'b1;
    step();
    wr_req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy_o || !rd_req_ready_o) && n < 20) begin
      step();
      n++;
    end
    check(nm, 128'({busy_o, rd_req_ready_o}), 128'(2'b01));
  endtask

  typedef struct {
    logic [6:0]    tr, tc, crow, ccol;
    logic [AW-1:0] addr;
    logic          err;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t  vecs [10];
    tile_t ones, d;
    string nm;
    vecs[0] = '{7'd1,  7'd2, 7'd32, 7'd32, AW'(136),  1'b0};
    vecs[1] = '{7'd0,  7'd0, 7'd32, 7'd32, AW'(0),    1'b0};
    vecs[2] = '{7'd7,  7'd7, 7'd32, 7'd32, AW'(924),  1'b0};
    vecs[3] = '{7'd8,  7'd0, 7'd32, 7'd32, AW'(0),    1'b1};
    vecs[4] = '{7'd0,  7'd8, 7'd32, 7'd32, AW'(0),    1'b1};
    vecs[5] = '{7'd0,  7'd7, 7'd32, 7'd30, AW'(0),    1'b1};
    vecs[6] = '{7'd0,  7'd0, 7'd32, 7'd0,  AW'(0),    1'b1};
    vecs[7] = '{7'd3,  7'd3, 7'd16, 7'd16, AW'(204),  1'b0};
    vecs[8] = '{7'd15, 7'd0, 7'd64, 7'd16, AW'(960),  1'b0};
    vecs[9] = '{7'd8,  7'd0, 7'd40, 7'd32, AW'(0),    1'b1};
    for (int k = 0; k < TileElems; k++) ones[k] = 8'(k + 1);

    rst_ni = 1'b0;
    set_cfg(7'd32, 7'd32);
    rd_req_valid_i = 1'b0; wr_req_valid_i = 1'b0; rd_rsp_ready_i = 1'b1;
    rd_tile_row_i = '0; rd_tile_col_i = '0; wr_tile_row_i = '0; wr_tile_col_i = '0;
    wr_data_i = '0;
    repeat (3) step();
    check("reset ctrl", 128'({rd_req_ready_o, wr_req_ready_o, rd_rsp_valid_o, rd_rsp_err_o,
                             wr_err_o, mem_we_o, busy_o}), 128'(0));
    check("reset addr", 128'({mem_addr_o, mem_matrix_col_o}), 128'(0));
    check("reset data", 128'(rd_rsp_data_o), 128'(0));
    check("reset wdata", 128'(mem_wr_data_o), 128'(0));
    rst_ni = 1'b1;
    step();
    check("post reset ready", 128'({rd_req_ready_o, wr_req_ready_o, busy_o}), 128'(3'b110));

    // Read vectors: addressing and bounds checks.
    for (int i = 0; i < 10; i++) begin
      set_cfg(vecs[i].crow, vecs[i].ccol);
      nm = $sformatf("vec%0d", i);
      do_read(nm, vecs[i].tr, vecs[i].tc, vecs[i].addr, vecs[i].err,
              vecs[i].err ? tile_t'(0) : exp_tile(vecs[i].addr, vecs[i].ccol));
    end

    // Write tile (0,7) then read it back.
    set_cfg(7'd32, 7'd32);
    do_write(7'd0, 7'd7, ones);
    check("wr acc", 128'({mem_we_o, wr_err_o, mem_addr_o}), 128'({1'b1, 1'b0, AW'(28)}));
    check("wr data", 128'(mem_wr_data_o), 128'(ones));
    step();
    check("wr single pulse", 128'({mem_we_o, mem_addr_o, busy_o}), 128'(0));
    do_read("readback", 7'd0, 7'd7, AW'(28), 1'b0, ones);

    // Rejected write.
    set_cfg(7'd32, 7'd30);
    do_write(7'd0, 7'd7, ones);
    check("wr err acc", 128'({wr_err_o, mem_we_o, mem_addr_o}), 128'({1'b1, 1'b0, AW'(0)}));
    step();
    check("wr err pulse", 128'({wr_err_o, mem_we_o}), 128'(0));

    // Ties straight after reset alternate RD, WR, RD.
    set_cfg(7'd32, 7'd32);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    for (int k = 0; k < TileElems; k++) d[k] = 8'(8'hA0 + k);
    rd_tile_row_i = 7'd0; rd_tile_col_i = 7'd0;
    wr_tile_row_i = 7'd1; wr_tile_col_i = 7'd1; wr_data_i = d;
    rd_req_valid_i = 1'b1; wr_req_valid_i = 1'b1;
    for (int g = 0; g < 3; g++) begin
      int n = 0;
      while (!rd_req_ready_o && n < 10) begin
        step();
        n++;
      end
      check($sformatf("tie%0d ready", g), 128'(rd_req_ready_o), 128'(1));
      step();
      if (g == 2) begin
        rd_req_valid_i = 1'b0; wr_req_valid_i = 1'b0;
      end
      check($sformatf("tie%0d grant", g), 128'({mem_we_o, mem_addr_o}),
            (g == 1) ? 128'({1'b1, AW'(132)}) : 128'({1'b0, AW'(0)}));
    end
    wait_idle("tie idle");

    // Backpressure: response held, write waits until after the handshake.
    rd_rsp_ready_i = 1'b0;
    rd_tile_row_i = 7'd1; rd_tile_col_i = 7'd2;
    rd_req_valid_i = 1'b1;
    step();
    rd_req_valid_i = 1'b0;
    step();
    wr_tile_row_i = 7'd2; wr_tile_col_i = 7'd2; wr_data_i = ones;
    wr_req_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp hold%0d", i),
            128'({rd_rsp_valid_o, rd_req_ready_o, wr_req_ready_o, rd_rsp_err_o,
                  rd_rsp_data_o === exp_tile(AW'(136), 7'd32)}), 128'(5'b10001));
      step();
    end
    rd_rsp_ready_i = 1'b1;
    check("bp handshake", 128'({rd_rsp_valid_o, wr_req_ready_o}), 128'(2'b10));
    step();
    check("bp release", 128'({rd_rsp_valid_o, wr_req_ready_o, mem_we_o}), 128'(3'b010));
    step();
    wr_req_valid_i = 1'b0;
    check("bp write", 128'({mem_we_o, mem_addr_o}), 128'({1'b1, AW'(264)}));
    wait_idle("bp idle");

    // Reset during WR_ACC drops the write.
    for (int k = 0; k < TileElems; k++) d[k] = 8'hEE;
    do_write(7'd3, 7'd0, d);
    check("rst wr acc", 128'({mem_we_o, mem_addr_o}), 128'({1'b1, AW'(384)}));
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst async", 128'({mem_we_o, busy_o, wr_err_o, rd_req_ready_o, wr_req_ready_o,
                            rd_rsp_valid_o, mem_addr_o, mem_matrix_col_o}), 128'(0));
    step();
    check("rst no write", 128'(mem[384]), 128'(init_val(384)));
    rst_ni = 1'b1;
    step();
    check("rst recover", 128'({rd_req_ready_o, busy_o, mem_we_o}), 128'(3'b100));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
